// File: rtl/tff_sched_pkg.sv
// tff_sched_pkg: shared state encoding and default sizes for tff_count_sched
package tff_sched_pkg;
    localparam int WIDTH_DEF   = 4;
    localparam int PRESC_W_DEF = 8;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;
endpackage

// File: rtl/tff_cell.sv
// tff_cell: single toggle flip-flop, q flips when t is high
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);
    always_ff @(posedge clk)
        q <= rst ? 1'b0 : q ^ t;
endmodule

// File: rtl/tff_count_sched.sv
// tff_count_sched: modulo up/down counter built from toggle cells; optional prescaler via TFF_SCHED_PRESCALE_EN
module tff_count_sched
    import tff_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
`ifdef TFF_SCHED_PRESCALE_EN
    ,
    parameter int PRESC_W = PRESC_W_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             up_dn,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef TFF_SCHED_PRESCALE_EN
    input  logic [PRESC_W-1:0] presc,
`endif
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] toggle_en,
    output logic             tc,
    output logic             busy,
    output logic             done
);
    state_t state, state_nxt;
    logic [WIDTH-1:0] nxt, lval;
    logic step, wrap, do_load;
`ifdef TFF_SCHED_PRESCALE_EN
    logic [PRESC_W-1:0] pcnt;
`endif
    always_comb begin
        lval      = load_val > limit ? limit : load_val;
        wrap      = up_dn ? count >= limit : count == '0;
        nxt       = up_dn ? (wrap ? '0 : count + WIDTH'(1))
                          : (wrap || count > limit ? limit : count - WIDTH'(1));
`ifdef TFF_SCHED_PRESCALE_EN
        step      = state == ST_RUN && !stop && pcnt == presc;
`else
        step      = state == ST_RUN && !stop;
`endif
        do_load   = state != ST_RUN && !stop && load;
        toggle_en = rst ? '0 : step ? count ^ nxt : do_load ? count ^ lval : '0;
        // stop leaves RUN for HOLD, and any other state for IDLE
        state_nxt = state == ST_RUN ? (stop ? ST_HOLD : step && wrap && oneshot ? ST_DONE : ST_RUN)
                  : stop ? ST_IDLE
                  : load ? state
                  : start ? ST_RUN : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            tc    <= 1'b0;
        end else begin
            state <= state_nxt;
            tc    <= step && wrap;
        end
    end
`ifdef TFF_SCHED_PRESCALE_EN
    always_ff @(posedge clk) begin
        if (rst || step || (state != ST_RUN && state_nxt == ST_RUN))
            pcnt <= '0;
        else if (state == ST_RUN)
            pcnt <= pcnt + PRESC_W'(1);
    end
`endif
    assign busy = state == ST_RUN;
    assign done = state == ST_DONE;
    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk(clk),
            .rst(rst),
            .t  (toggle_en[i]),
            .q  (count[i])
        );
    end
endmodule

// File: doc/tff_count_sched.md
Name: tff_count_sched

Overview:
- Sequencer for a bank of WIDTH toggle cells that together form a programmable modulo up/down counter.
- Each cycle the controller computes a per-bit toggle-enable vector and drives the cells with it. The cells hold the only count storage.
- Provides a start/stop/load control FSM, terminal-count pulse and one-shot completion.
- Sits beside timer/sequencer logic that needs a run-time modulus counter with a clean start/done handshake.

Parameters:
- WIDTH, 4, number of toggle cells (count width), legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  level; begin or resume counting
- stop  input  1  level; pause in RUN, return to IDLE from HOLD/DONE
- up_dn  input  1  1 = count up, 0 = count down; sampled every step
- oneshot  input  1  1 = halt in DONE at first terminal count; sampled every step
- limit  input  WIDTH  modulus minus 1 (counter range 0..limit)
- load  input  1  load request
- load_val  input  WIDTH  value to load
- count  output  WIDTH  toggle-cell outputs
- toggle_en  output  WIDTH  toggle vector applied this cycle, for observability
- tc  output  1  one-cycle pulse, registered, on the edge where a wrap step occurs
- busy  output  1  high in RUN
- done  output  1  high in DONE

Behaviour:
- Reset: on rst at a clock edge, the following apply. Rst has priority over every other input.
  - state = IDLE; count = 0 (all cells cleared).
  - tc = 0; busy = 0; done = 0; toggle_en = 0.
- States use a 2-bit encoding: IDLE, RUN, HOLD, DONE.
- Input priority within a cycle: rst > stop > load > start.
- IDLE:
  - load=1 → count = min(load_val, limit); stay IDLE.
  - Else start=1 → RUN.
  - Count is frozen.
- RUN:
  - One step per cycle, beginning with the first edge after entry. The edge that enters RUN does not step.
  - stop=1 → HOLD with no step that cycle.
  - load is ignored.
- HOLD:
  - Count is frozen.
  - start=1 → RUN; stop has priority.
  - stop=1 → IDLE with count retained.
  - load behaves as in IDLE.
- DONE:
  - Count is frozen.
  - start=1 → RUN, stepping from the current count.
  - stop=1 → IDLE.
  - load behaves as in IDLE.
- Step rule for next value:
  - Up: count >= limit → next = 0, wrap. Otherwise next = count+1.
  - Down: count == 0 → next = limit, wrap. count > limit → next = limit, no wrap. Otherwise next = count-1.
- Toggle vector:
  - toggle_en = count XOR next in a step cycle; 0 otherwise.
  - A load cycle uses count XOR min(load_val, limit).
  - count changes only through the toggle cells.
- Wrap:
  - tc = 1 for exactly the cycle after the wrap edge.
  - If oneshot = 1 at a wrap step, state → DONE on that same edge. done rises with tc.
- limit = 0: every step is a wrap and count stays 0. In continuous mode tc stays high throughout RUN.
- Changing limit while in RUN takes effect on the next step; no glitch handling is required.
- busy and done are decoded registered-state outputs. No combinational path runs from inputs to outputs except toggle_en.

Optional Feature:
- Macro TFF_SCHED_PRESCALE_EN.
- When defined:
  - Adds parameter PRESC_W (default 8), input presc (PRESC_W bits), and internal prescale counter pcnt.
  - A step occurs only on RUN cycles where pcnt == presc; otherwise pcnt increments.
  - pcnt clears on a step, on entering RUN and on rst.
  - presc = 0 is equivalent to no prescale.
- When undefined: a step occurs on every RUN cycle and no presc port exists.

Decomposition:
- Package tff_sched_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_HOLD=2'd2, ST_DONE=2'd3.
  - Default WIDTH and PRESC_W constants.
- Sub-module tff_cell: ports t, clk, rst, q; synchronous active-high reset to 0; q <= q ^ t. Instantiated WIDTH times via generate.
- The controller holds the FSM, next-value arithmetic and tc/done registers.

Test Plan:
- Reset mid-RUN: WIDTH=4, limit=9, up, count=5, assert rst for 1 cycle → count=0, IDLE, busy=0, tc=0 the next cycle.
- Continuous up: limit=9, start pulse → count 0,1,…,9,0. tc high only in the cycle count first shows 0 after 9. toggle_en at the 9→0 step = 4'b1001.
- One-shot down: load_val=3, limit=5, up_dn=0, oneshot=1, start → 3,2,1,0,5. DONE entered, done=1, busy=0. Count holds 5 for 10 idle cycles.
- Stop/resume and priority:
  - stop at count=4 → HOLD, count stays 4.
  - load=1 with load_val=12 while limit=9 → count=9.
  - start+stop together → goes to IDLE.
  - load asserted in RUN → ignored.
- Edge limits:
  - limit=0, up, continuous → count stays 0, tc=1 every RUN cycle.
  - limit lowered from 9 to 2 while count=7, up → next step wraps to 0 with tc.
- With TFF_SCHED_PRESCALE_EN, presc=2 → count advances every 3rd RUN cycle. presc=0 → every cycle.
